// File: rtl/control_unit.sv
// Control path for the single-cycle ARM datapath: instruction decoder,
// condition check and the architectural NZCV flags register.
module control_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic        CondEx
);

  typedef enum logic [1:0] {
    OP_DP    = 2'b00,
    OP_MEM   = 2'b01,
    OP_BR    = 2'b10,
    OP_UNDEF = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100
  } cmd_e;

  logic [3:0] cond;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit;
  logic       s_bit;
  logic       l_bit;
  logic       u_bit;
  logic [3:0] rd;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign i_bit = Instr[25];
  assign cmd   = Instr[24:21];
  assign s_bit = Instr[20];
  assign l_bit = Instr[20];
  assign u_bit = Instr[23];
  assign rd    = Instr[15:12];

  // Register-number and offset fields belong to the datapath, not to control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  logic       branch;
  logic       regw_dec;
  logic       memw_dec;
  logic [1:0] flagw_dec;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    branch     = 1'b0;
    regw_dec   = 1'b0;
    memw_dec   = 1'b0;
    flagw_dec  = 2'b00;
    MemtoReg   = 1'b0;
    ALUSrc     = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = 2'b00;

    unique case (op)
      OP_DP: begin
        ALUSrc = i_bit ? 2'b01 : 2'b00;
        unique case (cmd)
          CMD_ADD: begin
            ALUControl = 2'b00;
            regw_dec   = 1'b1;
            flagw_dec  = {s_bit, s_bit};
          end
          CMD_SUB: begin
            ALUControl = 2'b01;
            regw_dec   = 1'b1;
            flagw_dec  = {s_bit, s_bit};
          end
          CMD_AND: begin
            ALUControl = 2'b10;
            regw_dec   = 1'b1;
            flagw_dec  = {s_bit, 1'b0};
          end
          CMD_ORR: begin
            ALUControl = 2'b11;
            regw_dec   = 1'b1;
            flagw_dec  = {s_bit, 1'b0};
          end
          CMD_CMP: begin
            ALUControl = 2'b01;
            flagw_dec  = {s_bit, s_bit};
          end
          default: ;
        endcase
      end
      OP_MEM: begin
        ALUControl = u_bit ? 2'b00 : 2'b01;
        ALUSrc     = 2'b01;
        ImmSrc     = 2'b01;
        if (l_bit) begin
          regw_dec = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          memw_dec = 1'b1;
          RegSrc   = 2'b10;
        end
      end
      OP_BR: begin
        branch = 1'b1;
        ALUSrc = 2'b01;
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      OP_UNDEF: ;
      default: ;
    endcase
  end

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = Flags;

  always_comb begin
    CondEx = 1'b0;
    unique case (cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // Architectural side effects are suppressed while the condition fails or
  // the core is held in reset.
  logic       exec_ok;
  logic [1:0] flag_we;

  assign exec_ok  = CondEx & ~reset;
  assign PCSrc    = exec_ok & (branch | (regw_dec & (rd == 4'hF)));
  assign RegWrite = exec_ok & regw_dec;
  assign MemWrite = exec_ok & memw_dec;
  assign flag_we  = flagw_dec & {2{exec_ok}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what lets CondEx see the old flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      Flags <= FLAGS_RST;
    end else begin
      if (flag_we[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flag_we[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Control path for the single-cycle ARM datapath (fetch/decode/execution/memory/write-back).
- Consumes Instr and ALUFlags from the datapath and drives every datapath control input: PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl.
- Contains the instruction decoder, condition-check logic and the architectural NZCV flags register.
- Only sequential state is the flags register; all control outputs are combinational from Instr, the registered flags and reset.

Parameters:
- FLAGS_RST, 4'b0000, value loaded into the flags register {N,Z,C,V} on reset.

Ports:
- CLK  in  1  datapath clock, rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  current instruction from fetch.
- ALUFlags  in  4  {N,Z,C,V} from execution, current cycle.
- PCSrc  out  1  1 = PC loads Result.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- MemtoReg  out  1  1 = Result selects ReadData.
- ALUSrc  out  2  00 = RD2; 01 = extended immediate; 1x never driven.
- ImmSrc  out  2  00 = imm8 zero-extended; 01 = imm12 zero-extended; 10 = imm24 sign-extended <<2.
- RegSrc  out  2  bit0 = RA1 is R15; bit1 = RA2 is Rd.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- Flags  out  4  registered {N,Z,C,V}.
- CondEx  out  1  condition field passed, using registered Flags.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high.
- Reset:
  - At the rising CLK edge with reset=1, Flags<=FLAGS_RST.
  - While reset=1, PCSrc, RegWrite and MemWrite are forced to 0.
  - Other outputs decode normally during reset.
- Decode, Op = Instr[27:26], Funct = Instr[25:20]:
  - Op=00 (data-processing):
    - I = Funct[5], cmd = Funct[4:1], S = Funct[0].
    - ALUSrc = I ? 01 : 00; ImmSrc = 00; RegSrc = 00; MemtoReg = 0.
    - cmd 0100 ADD -> 00; cmd 0010 SUB -> 01; cmd 0000 AND -> 10; cmd 1100 ORR -> 11.
    - cmd 1010 CMP -> ALUControl = 01, RegWrite = 0 (S must be 1).
    - Any other cmd is unsupported: RegWrite = 0, no flag write, ALUControl = 00.
    - Supported non-CMP cmd: RegWrite = 1.
  - Op=01 (memory):
    - L = Funct[0], U = Funct[3]; ALUControl = U ? 00 : 01; ALUSrc = 01; ImmSrc = 01.
    - LDR (L=1): RegWrite = 1, MemtoReg = 1, RegSrc = 00.
    - STR (L=0): MemWrite = 1, RegWrite = 0, RegSrc = 10.
  - Op=10 (branch): Branch = 1; ALUSrc = 01; ImmSrc = 10; RegSrc = 01; ALUControl = 00; RegWrite = 0.
  - Op=11 (undefined): all write enables 0, PCSrc = 0, remaining outputs 00/0.
- Flag write:
  - FlagW[1] (NZ) = S on a supported data-processing op.
  - FlagW[0] (CV) = S and cmd in {ADD, SUB, CMP}.
  - No flag write from memory or branch instructions.
- Condition, cond = Instr[31:28]:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 -> 0 (never).
- Gating:
  - PCSrc = CondEx & (Branch | (RegW_dec & Rd==15)).
  - RegWrite = CondEx & RegW_dec; MemWrite = CondEx & MemW_dec.
  - Flag write enables are ANDed with CondEx and with !reset.
- Flags update:
  - On the rising CLK edge, Flags[3:2] <= ALUFlags[3:2] if FlagW[1] is enabled.
  - On the same edge, Flags[1:0] <= ALUFlags[1:0] if FlagW[0] is enabled.
  - Halves update independently.
- Latency: control outputs are zero-cycle combinational; a flag written by instruction k is first visible to the condition check of instruction k+1.
- Simultaneous events:
  - Condition evaluation always uses pre-edge Flags, including when the same instruction writes flags.
  - Reset and a flag write in the same cycle: reset wins.

Test Plan:
- reset=1, Instr=0xE0810002, ALUFlags=1111 -> RegWrite=0, PCSrc=0, MemWrite=0; after the edge Flags=0000.
- ADD R0,R1,R2 0xE0810002 -> RegWrite=1, ALUControl=00, ALUSrc=00, MemtoReg=0, PCSrc=0, Flags unchanged after the edge.
- SUBS R0,R1,#1 0xE2510001 with ALUFlags=0110 -> ALUSrc=01, ImmSrc=00, ALUControl=01, RegWrite=1; next cycle Flags=0110.
  - Then CMP R1,R2 0xE1510002 with ALUFlags=1000 -> RegWrite=0, ALUControl=01, next Flags=1000.
- BEQ 0x0A000002:
  - with Flags Z=1 -> PCSrc=1, ImmSrc=10, RegSrc=01, ALUSrc=01.
  - with Z=0 -> PCSrc=0.
  - ADDSEQ 0x00910002 with Z=0, ALUFlags=1111 -> RegWrite=0, Flags unchanged.
- LDR R0,[R1,#4] 0xE5910004 -> RegWrite=1, MemtoReg=1, ALUSrc=01, ImmSrc=01, ALUControl=00.
  - STR 0xE5810004 -> MemWrite=1, RegWrite=0, RegSrc=10.
  - LDR with U=0, 0xE5110004 -> ALUControl=01.
- ADD PC,PC,R2 0xE08FF002 -> PCSrc=1, RegWrite=1.
  - cond=1111, 0xF0810002 -> all enables 0.
  - Op=11, 0xEC000000 -> all enables 0, Flags unchanged.
